// File: rtl/stream_demux.sv
// stream_demux: steers one valid/ready input stream into NCH one-entry output slots,
// by unicast or broadcast, and counts words addressed to nonexistent channels.
module stream_demux #(
  parameter int DW   = 32,
  parameter int NCH  = 8,
  parameter int SELW = 4,
  parameter int CNTW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [SELW-1:0]   in_sel,
  input  logic              in_bcast,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH*DW-1:0] out_data,
  output logic [CNTW-1:0]   drop_cnt
);

  logic [NCH-1:0]    r_valid;
  logic [NCH*DW-1:0] r_data;
  logic [CNTW-1:0]   r_drop_cnt;

  logic [NCH-1:0]    w_free;
  logic [NCH-1:0]    w_drain;
  logic [NCH-1:0]    w_sel_hit;
  logic [NCH-1:0]    w_load;
  logic              w_in_range;
  logic              w_sel_free;
  logic              w_ready;
  logic              w_accept;
  logic              w_drop;

  // Decode in_sel without indexing past NCH; no hit means out of range.
  always_comb begin
    w_sel_hit = '0;
    for (int k = 0; k < NCH; k++) begin
      if (in_sel == SELW'(k)) begin
        w_sel_hit[k] = 1'b1;
      end else begin
        w_sel_hit[k] = 1'b0;
      end
    end
  end

  assign w_free     = ~r_valid | out_ready;
  assign w_drain    = r_valid & out_ready;
  assign w_in_range = |w_sel_hit;
  assign w_sel_free = |(w_sel_hit & w_free);

  always_comb begin
    w_ready = 1'b0;
    if (flush || !en) begin
      w_ready = 1'b0;
    end else if (in_bcast) begin
      w_ready = &w_free;
    end else if (!w_in_range) begin
      w_ready = 1'b1;
    end else begin
      w_ready = w_sel_free;
    end
  end

  assign w_accept = in_valid & w_ready;
  assign w_load   = {NCH{w_accept}} & ({NCH{in_bcast}} | w_sel_hit);
  assign w_drop   = w_accept & ~in_bcast & ~w_in_range;

  // Slot update: flush beats load beats drain, so load+drain keeps the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (flush) begin
          r_valid[k] <= 1'b0;
        end else if (w_load[k]) begin
          r_valid[k]          <= 1'b1;
          r_data[k*DW +: DW]  <= in_data;
        end else if (w_drain[k]) begin
          r_valid[k] <= 1'b0;
        end else begin
          r_valid[k] <= r_valid[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {CNTW{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + CNTW'(1);
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: vector table with expected in_ready/out_valid/drop_cnt,
// per-channel drain scoreboard, plus hand-written saturation and async-reset sequences.
module tb_stream_demux;

  logic         clk = 1'b0;
  logic         rst_n, en, flush, in_valid, in_bcast, in_ready;
  logic [31:0]  in_data;
  logic [3:0]   in_sel;
  logic [7:0]   out_valid, out_ready, drop_cnt;
  logic [255:0] out_data;

  logic         b_in_valid, b_in_ready, b_bcast;
  logic [31:0]  b_in_data;
  logic [2:0]   b_in_sel;
  logic [5:0]   b_out_valid, b_out_ready;
  logic [191:0] b_out_data;
  logic [1:0]   b_drop_cnt;

  always #5 clk = ~clk;

  stream_demux #(.DW(32), .NCH(8), .SELW(4), .CNTW(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt)
  );

  stream_demux #(.DW(32), .NCH(6), .SELW(3), .CNTW(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_sel(b_in_sel), .in_bcast(b_bcast),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .drop_cnt(b_drop_cnt)
  );

  typedef struct {
    logic        v;
    logic [3:0]  sel;
    logic        bc;
    logic [31:0] d;
    logic [7:0]  ordy;
    logic        en;
    logic        fl;
    logic        exp_rdy;
    logic [7:0]  exp_ov;
    logic [7:0]  exp_drop;
  } vec_t;

  typedef struct {
    int          ch;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [3:0] sel, input logic bc,
                              input logic [31:0] d, input logic [7:0] ordy, input logic e,
                              input logic fl, input logic rdy, input logic [7:0] ov,
                              input logic [7:0] drop);
    vec_t t;
    t.v = v; t.sel = sel; t.bc = bc; t.d = d; t.ordy = ordy; t.en = e; t.fl = fl;
    t.exp_rdy = rdy; t.exp_ov = ov; t.exp_drop = drop;
    return t;
  endfunction

  // Called at posedge+1: drive, check in_ready mid-cycle, check registered state after the edge.
  task automatic apply(input vec_t t, input int idx);
    exp_t e;
    in_valid = t.v; in_sel = t.sel; in_bcast = t.bc; in_data = t.d;
    out_ready = t.ordy; en = t.en; flush = t.fl;
    #3;
    chk($sformatf("in_ready[%0d]", idx), {63'd0, in_ready}, {63'd0, t.exp_rdy});
    if (t.v && t.exp_rdy) begin
      if (t.bc) begin
        for (int k = 0; k < 8; k++) begin
          e.ch = k; e.d = t.d; sb.push_back(e);
        end
      end else if (t.sel < 4'd8) begin
        e.ch = int'(t.sel); e.d = t.d; sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (t.fl) sb.delete();
    chk($sformatf("out_valid[%0d]", idx), {56'd0, out_valid}, {56'd0, t.exp_ov});
    chk($sformatf("drop_cnt[%0d]", idx), {56'd0, drop_cnt}, {56'd0, t.exp_drop});
  endtask

  // Every handshake on an output channel must deliver that channel's oldest expected word.
  always @(negedge clk) begin
    int idx;
    if (rst_n) begin
      for (int k = 0; k < 8; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          idx = -1;
          for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].ch == k) idx = i;
          end
          if (idx < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_ch%0d: got %0h, required no drain", k, out_data[k*32 +: 32]);
          end else begin
            chk($sformatf("drain_ch%0d", k), {32'd0, out_data[k*32 +: 32]}, {32'd0, sb[idx].d});
            sb.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    logic [1:0] exp_b [5];
    exp_b = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    rst_n = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_bcast = 1'b0;
    in_data = 32'd0; in_sel = 4'd0; out_ready = 8'hFF;
    b_in_valid = 1'b0; b_bcast = 1'b0; b_in_data = 32'd0; b_in_sel = 3'd0; b_out_ready = 6'h3F;

    //             v     sel    bc    data           ordy   en    fl    rdy   ov     drop
    tbl.push_back(mk(1'b1, 4'd3, 1'b0, 32'hA5A5_0001, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h08, 8'd0));
    tbl.push_back(mk(1'b0, 4'd0, 1'b0, 32'h0,         8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, 8'd0));
    tbl.push_back(mk(1'b1, 4'd5, 1'b0, 32'h11,        8'hDF, 1'b1, 1'b0, 1'b1, 8'h20, 8'd0));
    tbl.push_back(mk(1'b1, 4'd5, 1'b0, 32'h22,        8'hDF, 1'b1, 1'b0, 1'b0, 8'h20, 8'd0));
    tbl.push_back(mk(1'b1, 4'd5, 1'b0, 32'h22,        8'hFF, 1'b1, 1'b0, 1'b1, 8'h20, 8'd0));
    tbl.push_back(mk(1'b0, 4'd0, 1'b0, 32'h0,         8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, 8'd0));
    tbl.push_back(mk(1'b1, 4'd2, 1'b0, 32'h33,        8'hFB, 1'b1, 1'b0, 1'b1, 8'h04, 8'd0));
    tbl.push_back(mk(1'b1, 4'd0, 1'b1, 32'hFFFF_0000, 8'hFB, 1'b1, 1'b0, 1'b0, 8'h04, 8'd0));
    tbl.push_back(mk(1'b1, 4'd0, 1'b1, 32'hFFFF_0000, 8'hFB, 1'b1, 1'b0, 1'b0, 8'h04, 8'd0));
    tbl.push_back(mk(1'b1, 4'd0, 1'b1, 32'hFFFF_0000, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 8'd0));
    tbl.push_back(mk(1'b0, 4'd0, 1'b0, 32'h0,         8'h00, 1'b1, 1'b0, 1'b0, 8'hFF, 8'd0));
    tbl.push_back(mk(1'b0, 4'd0, 1'b0, 32'h0,         8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, 8'd0));
    tbl.push_back(mk(1'b1, 4'd8, 1'b0, 32'h44,        8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, 8'd1));
    tbl.push_back(mk(1'b1, 4'd15, 1'b0, 32'h45,       8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, 8'd2));
    tbl.push_back(mk(1'b1, 4'd7, 1'b0, 32'h77,        8'hFF, 1'b1, 1'b0, 1'b1, 8'h80, 8'd2));
    tbl.push_back(mk(1'b0, 4'd0, 1'b0, 32'h0,         8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, 8'd2));
    tbl.push_back(mk(1'b1, 4'd0, 1'b0, 32'h50,        8'hFC, 1'b1, 1'b0, 1'b1, 8'h01, 8'd2));
    tbl.push_back(mk(1'b1, 4'd1, 1'b0, 32'h51,        8'hFC, 1'b1, 1'b0, 1'b1, 8'h03, 8'd2));
    tbl.push_back(mk(1'b1, 4'd0, 1'b0, 32'h52,        8'hFC, 1'b1, 1'b1, 1'b0, 8'h00, 8'd2));
    tbl.push_back(mk(1'b1, 4'd0, 1'b0, 32'h53,        8'hFC, 1'b1, 1'b0, 1'b1, 8'h01, 8'd2));
    tbl.push_back(mk(1'b0, 4'd0, 1'b0, 32'h0,         8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 8'd2));
    tbl.push_back(mk(1'b1, 4'd2, 1'b0, 32'h60,        8'hFB, 1'b1, 1'b0, 1'b1, 8'h04, 8'd2));
    tbl.push_back(mk(1'b1, 4'd3, 1'b0, 32'h61,        8'hFB, 1'b0, 1'b0, 1'b0, 8'h04, 8'd2));
    tbl.push_back(mk(1'b1, 4'd3, 1'b0, 32'h61,        8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 8'd2));
    tbl.push_back(mk(1'b1, 4'd3, 1'b0, 32'h61,        8'hFF, 1'b1, 1'b0, 1'b1, 8'h08, 8'd2));
    tbl.push_back(mk(1'b0, 4'd0, 1'b0, 32'h0,         8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, 8'd2));
    tbl.push_back(mk(1'b1, 4'd4, 1'b0, 32'h70,        8'hFF, 1'b1, 1'b0, 1'b1, 8'h10, 8'd2));
    tbl.push_back(mk(1'b1, 4'd4, 1'b0, 32'h71,        8'hFF, 1'b1, 1'b0, 1'b1, 8'h10, 8'd2));
    tbl.push_back(mk(1'b1, 4'd4, 1'b0, 32'h72,        8'hFF, 1'b1, 1'b0, 1'b1, 8'h10, 8'd2));
    tbl.push_back(mk(1'b0, 4'd0, 1'b0, 32'h0,         8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, 8'd2));
    tbl.push_back(mk(1'b1, 4'd15, 1'b1, 32'h99,       8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 8'd2));
    tbl.push_back(mk(1'b0, 4'd0, 1'b0, 32'h0,         8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, 8'd2));

    #12;
    chk("rst_out_valid", {56'd0, out_valid}, 64'd0);
    chk("rst_out_data_nonzero", {63'd0, |out_data}, 64'd0);
    chk("rst_drop_cnt", {56'd0, drop_cnt}, 64'd0);
    chk("rst_small_drop_cnt", {62'd0, b_drop_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Narrow instance: out-of-range words are accepted and the 2-bit counter saturates.
    for (int i = 0; i < 5; i++) begin
      b_in_valid = 1'b1; b_in_sel = 3'd7; b_in_data = 32'h100 + i;
      #3;
      chk($sformatf("small_in_ready[%0d]", i), {63'd0, b_in_ready}, 64'd1);
      @(posedge clk);
      #1;
      chk($sformatf("small_out_valid[%0d]", i), {58'd0, b_out_valid}, 64'd0);
      chk($sformatf("small_drop_cnt[%0d]", i), {62'd0, b_drop_cnt}, {62'd0, exp_b[i]});
    end
    b_in_valid = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
    chk("sb_empty_after_table", 64'(sb.size()), 64'd0);

    // Asynchronous reset between edges with three full slots and drop_cnt=2.
    apply(mk(1'b1, 4'd0, 1'b0, 32'h81, 8'h00, 1'b1, 1'b0, 1'b1, 8'h01, 8'd2), 100);
    apply(mk(1'b1, 4'd1, 1'b0, 32'h82, 8'h00, 1'b1, 1'b0, 1'b1, 8'h03, 8'd2), 101);
    apply(mk(1'b1, 4'd2, 1'b0, 32'h83, 8'h00, 1'b1, 1'b0, 1'b1, 8'h07, 8'd2), 102);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", {56'd0, out_valid}, 64'd0);
    chk("async_out_data_nonzero", {63'd0, |out_data}, 64'd0);
    chk("async_drop_cnt", {56'd0, drop_cnt}, 64'd0);
    sb.delete();
    in_valid = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(mk(1'b1, 4'd6, 1'b0, 32'h90, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h40, 8'd0), 103);
    apply(mk(1'b0, 4'd0, 1'b0, 32'h0,  8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, 8'd0), 104);
    chk("sb_empty_final", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
